// File: rtl/delay_line.sv
// Programmable delay stage: waits delay*U clocks after a launch edge, emits one pulse of width*U clocks,
// then holds launch_next for the next stage. Optional macro DL_LATCH_EN makes a launch fall non-aborting.
module delay_line #(
    parameter int UNIT_1 = 1,
    parameter int UNIT_2 = 100,
    parameter int UNIT_3 = 100000
) (
    input  logic        clk_DL,
    input  logic        rst_DL,
    input  logic        DL_launch,
    input  logic [4:0]  dl_mlt,
    input  logic [16:0] delay,
    input  logic [16:0] width,
    output logic        DL_out,
    output logic        DL_busy,
    output logic        launch_next
);

    localparam logic [16:0] U1 = 17'(UNIT_1);
    localparam logic [16:0] U2 = 17'(UNIT_2);
    localparam logic [16:0] U3 = 17'(UNIT_3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state_reg;
    logic        launch_prev_reg;
    logic [16:0] presc_reg;
    logic [16:0] count_reg;
    logic [16:0] delay_lat_reg;
    logic [16:0] width_lat_reg;
    logic [16:0] unit_lat_reg;

    logic        launch_edge;
    logic        tick;
    logic        abort;
    logic [16:0] unit_sel;
    logic [16:0] count_inc;

    always_comb begin
        unit_sel = U3;
        if (dl_mlt == 5'd1) begin
            unit_sel = U1;
        end else if (dl_mlt == 5'd2) begin
            unit_sel = U2;
        end
    end

    assign launch_edge = DL_launch & ~launch_prev_reg;
    assign tick        = (presc_reg == (unit_lat_reg - 17'd1));
    assign count_inc   = count_reg + 17'd1;

`ifdef DL_LATCH_EN
    assign abort = 1'b0;
`else
    assign abort = ~DL_launch;
`endif

    // Counter updates sit before the case so every state transition below can clear them.
    always_ff @(posedge clk_DL) begin
        if (rst_DL) begin
            state_reg       <= IDLE;
            launch_prev_reg <= 1'b0;
            presc_reg       <= '0;
            count_reg       <= '0;
            delay_lat_reg   <= '0;
            width_lat_reg   <= '0;
            unit_lat_reg    <= '0;
            DL_out          <= 1'b0;
            DL_busy         <= 1'b0;
            launch_next     <= 1'b0;
        end else begin
            launch_prev_reg <= DL_launch;
            if (tick) begin
                presc_reg <= '0;
                count_reg <= count_inc;
            end else begin
                presc_reg <= presc_reg + 17'd1;
            end

            case (state_reg)
                IDLE: begin
                    presc_reg <= '0;
                    count_reg <= '0;
                    if (launch_edge) begin
                        delay_lat_reg <= delay;
                        width_lat_reg <= width;
                        unit_lat_reg  <= unit_sel;
                        if (delay != '0) begin
                            state_reg <= DELAY;
                            DL_busy   <= 1'b1;
                        end else if (width != '0) begin
                            state_reg <= PULSE;
                            DL_busy   <= 1'b1;
                            DL_out    <= 1'b1;
                        end else begin
                            state_reg   <= HOLD;
                            launch_next <= 1'b1;
                        end
                    end
                end

                // The delay compare uses the registered count, so the exit happens one cycle after the final tick.
                DELAY: begin
                    if (abort) begin
                        state_reg <= IDLE;
                        DL_busy   <= 1'b0;
                        presc_reg <= '0;
                        count_reg <= '0;
                    end else if (count_reg == delay_lat_reg) begin
                        presc_reg <= '0;
                        count_reg <= '0;
                        if (width_lat_reg != '0) begin
                            state_reg <= PULSE;
                            DL_out    <= 1'b1;
                        end else begin
                            state_reg   <= HOLD;
                            DL_busy     <= 1'b0;
                            launch_next <= 1'b1;
                        end
                    end
                end

                PULSE: begin
                    if (abort) begin
                        state_reg <= IDLE;
                        DL_out    <= 1'b0;
                        DL_busy   <= 1'b0;
                        presc_reg <= '0;
                        count_reg <= '0;
                    end else if (tick && (count_inc == width_lat_reg)) begin
                        state_reg   <= HOLD;
                        DL_out      <= 1'b0;
                        DL_busy     <= 1'b0;
                        launch_next <= 1'b1;
                        presc_reg   <= '0;
                        count_reg   <= '0;
                    end
                end

                HOLD: begin
                    presc_reg <= '0;
                    count_reg <= '0;
                    if (!DL_launch) begin
                        state_reg   <= IDLE;
                        launch_next <= 1'b0;
                    end
                end

                default: begin
                    state_reg   <= IDLE;
                    DL_out      <= 1'b0;
                    DL_busy     <= 1'b0;
                    launch_next <= 1'b0;
                    presc_reg   <= '0;
                    count_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_line.sv
// Directed self-checking bench for delay_line; j counts clock edges after the launch edge k.
module tb_delay_line;

    logic        clk_DL = 1'b0;
    logic        rst_DL;
    logic        DL_launch;
    logic [4:0]  dl_mlt;
    logic [16:0] delay;
    logic [16:0] width;
    logic        DL_out;
    logic        DL_busy;
    logic        launch_next;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_DL = ~clk_DL;

    delay_line dut (
        .clk_DL      (clk_DL),
        .rst_DL      (rst_DL),
        .DL_launch   (DL_launch),
        .dl_mlt      (dl_mlt),
        .delay       (delay),
        .width       (width),
        .DL_out      (DL_out),
        .DL_busy     (DL_busy),
        .launch_next (launch_next)
    );

    task automatic step();
        @(posedge clk_DL);
        #1;
    endtask

    task automatic idle_gap();
        DL_launch = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst_DL = 1'b1; DL_launch = 1'b1; dl_mlt = 5'd1; delay = 17'd0; width = 17'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp += 3;
            if (DL_out !== 1'b0)      begin n_err++; $display("FAIL reset_out i=%0d got %b want 0", i, DL_out); end
            if (DL_busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy i=%0d got %b want 0", i, DL_busy); end
            if (launch_next !== 1'b0) begin n_err++; $display("FAIL reset_next i=%0d got %b want 0", i, launch_next); end
        end
        rst_DL = 1'b0; DL_launch = 1'b0;
        step();
        n_cmp += 2;
        if (DL_busy !== 1'b0)     begin n_err++; $display("FAIL reset_rel_busy got %b want 0", DL_busy); end
        if (launch_next !== 1'b0) begin n_err++; $display("FAIL reset_rel_next got %b want 0", launch_next); end
        $display("test_reset done");
    endtask

    // delay=5, width=3, unit 1: DL_out high after edges k+6..k+8, launch_next from k+9.
    task automatic test_basic();
        logic eo, eb, en;
        dl_mlt = 5'd1; delay = 17'd5; width = 17'd3;
        DL_launch = 1'b1;
        step();
        for (int j = 0; j <= 11; j++) begin
            eo = (j >= 6) && (j <= 8);
            eb = (j <= 8);
            en = (j >= 9);
            n_cmp += 3;
            if (DL_out !== eo)      begin n_err++; $display("FAIL basic_out j=%0d got %b want %b", j, DL_out, eo); end
            if (DL_busy !== eb)     begin n_err++; $display("FAIL basic_busy j=%0d got %b want %b", j, DL_busy, eb); end
            if (launch_next !== en) begin n_err++; $display("FAIL basic_next j=%0d got %b want %b", j, launch_next, en); end
            if (j < 11) step();
        end
        DL_launch = 1'b0;
        step();
        n_cmp += 2;
        if (launch_next !== 1'b0) begin n_err++; $display("FAIL basic_next_fall got %b want 0", launch_next); end
        if (DL_busy !== 1'b0)     begin n_err++; $display("FAIL basic_busy_end got %b want 0", DL_busy); end
        step();
        $display("test_basic delay=5 width=3 unit=1 done");
    endtask

    // Unit 100, delay=2, width=1: DL_out high after edges k+201..k+300.
    task automatic test_unit100();
        logic eo, eb, en;
        dl_mlt = 5'd2; delay = 17'd2; width = 17'd1;
        DL_launch = 1'b1;
        step();
        for (int j = 0; j <= 305; j++) begin
            eo = (j >= 201) && (j <= 300);
            eb = (j <= 300);
            en = (j >= 301);
            n_cmp += 3;
            if (DL_out !== eo)      begin n_err++; $display("FAIL u100_out j=%0d got %b want %b", j, DL_out, eo); end
            if (DL_busy !== eb)     begin n_err++; $display("FAIL u100_busy j=%0d got %b want %b", j, DL_busy, eb); end
            if (launch_next !== en) begin n_err++; $display("FAIL u100_next j=%0d got %b want %b", j, launch_next, en); end
            if (j < 305) step();
        end
        idle_gap();
        $display("test_unit100 delay=2 width=1 unit=100 done");
    endtask

    task automatic test_zero_delay();
        logic eo, eb, en;
        dl_mlt = 5'd1; delay = 17'd0; width = 17'd4;
        DL_launch = 1'b1;
        step();
        for (int j = 0; j <= 6; j++) begin
            eo = (j <= 3);
            eb = (j <= 3);
            en = (j >= 4);
            n_cmp += 3;
            if (DL_out !== eo)      begin n_err++; $display("FAIL zd_out j=%0d got %b want %b", j, DL_out, eo); end
            if (DL_busy !== eb)     begin n_err++; $display("FAIL zd_busy j=%0d got %b want %b", j, DL_busy, eb); end
            if (launch_next !== en) begin n_err++; $display("FAIL zd_next j=%0d got %b want %b", j, launch_next, en); end
            if (j < 6) step();
        end
        idle_gap();
        delay = 17'd0; width = 17'd0;
        DL_launch = 1'b1;
        step();
        for (int j = 0; j <= 3; j++) begin
            n_cmp += 3;
            if (DL_out !== 1'b0)      begin n_err++; $display("FAIL zz_out j=%0d got %b want 0", j, DL_out); end
            if (DL_busy !== 1'b0)     begin n_err++; $display("FAIL zz_busy j=%0d got %b want 0", j, DL_busy); end
            if (launch_next !== 1'b1) begin n_err++; $display("FAIL zz_next j=%0d got %b want 1", j, launch_next); end
            if (j < 3) step();
        end
        idle_gap();
        $display("test_zero_delay width=4 and width=0 done");
    endtask

    // Launch falls after edge k+4 (unit count 4) while still in DELAY.
    task automatic test_abort();
        logic eo, eb, en;
        dl_mlt = 5'd1; delay = 17'd10; width = 17'd2;
        DL_launch = 1'b1;
        step();
        for (int j = 0; j <= 4; j++) begin
            n_cmp += 2;
            if (DL_busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_pre j=%0d got %b want 1", j, DL_busy); end
            if (DL_out !== 1'b0)  begin n_err++; $display("FAIL abort_out_pre j=%0d got %b want 0", j, DL_out); end
            if (j < 4) step();
        end
        DL_launch = 1'b0;
        step();
        for (int j = 5; j <= 16; j++) begin
`ifdef DL_LATCH_EN
            eo = (j >= 11) && (j <= 12);
            eb = (j <= 12);
            en = (j == 13);
`else
            eo = 1'b0;
            eb = 1'b0;
            en = 1'b0;
`endif
            n_cmp += 3;
            if (DL_out !== eo)      begin n_err++; $display("FAIL abort_out j=%0d got %b want %b", j, DL_out, eo); end
            if (DL_busy !== eb)     begin n_err++; $display("FAIL abort_busy j=%0d got %b want %b", j, DL_busy, eb); end
            if (launch_next !== en) begin n_err++; $display("FAIL abort_next j=%0d got %b want %b", j, launch_next, en); end
            if (j < 16) step();
        end
        idle_gap();
        $display("test_abort delay=10 drop at count 4 done");
    endtask

    task automatic test_input_change();
        logic eo, en;
        dl_mlt = 5'd1; delay = 17'd5; width = 17'd3;
        DL_launch = 1'b1;
        step();
        for (int j = 0; j <= 11; j++) begin
            if (j == 2) begin
                delay = 17'd50; width = 17'd9; dl_mlt = 5'd2;
            end
            eo = (j >= 6) && (j <= 8);
            en = (j >= 9);
            n_cmp += 2;
            if (DL_out !== eo)      begin n_err++; $display("FAIL chg_out j=%0d got %b want %b", j, DL_out, eo); end
            if (launch_next !== en) begin n_err++; $display("FAIL chg_next j=%0d got %b want %b", j, launch_next, en); end
            if (j < 11) step();
        end
        idle_gap();
        $display("test_input_change delay 5->50 after launch done");
    endtask

    task automatic test_reset_mid();
        logic eo, eb, en;
        dl_mlt = 5'd1; delay = 17'd2; width = 17'd10;
        DL_launch = 1'b1;
        step();
        for (int j = 1; j <= 5; j++) step();
        n_cmp += 1;
        if (DL_out !== 1'b1) begin n_err++; $display("FAIL rmid_pulse got %b want 1", DL_out); end
        rst_DL = 1'b1; DL_launch = 1'b0;
        step();
        n_cmp += 3;
        if (DL_out !== 1'b0)      begin n_err++; $display("FAIL rmid_out got %b want 0", DL_out); end
        if (DL_busy !== 1'b0)     begin n_err++; $display("FAIL rmid_busy got %b want 0", DL_busy); end
        if (launch_next !== 1'b0) begin n_err++; $display("FAIL rmid_next got %b want 0", launch_next); end
        rst_DL = 1'b0;
        step();
        n_cmp += 1;
        if (DL_busy !== 1'b0) begin n_err++; $display("FAIL rmid_idle_busy got %b want 0", DL_busy); end
        delay = 17'd1; width = 17'd2;
        DL_launch = 1'b1;
        step();
        for (int j = 0; j <= 5; j++) begin
            eo = (j >= 2) && (j <= 3);
            eb = (j <= 3);
            en = (j >= 4);
            n_cmp += 3;
            if (DL_out !== eo)      begin n_err++; $display("FAIL rmid_re_out j=%0d got %b want %b", j, DL_out, eo); end
            if (DL_busy !== eb)     begin n_err++; $display("FAIL rmid_re_busy j=%0d got %b want %b", j, DL_busy, eb); end
            if (launch_next !== en) begin n_err++; $display("FAIL rmid_re_next j=%0d got %b want %b", j, launch_next, en); end
            if (j < 5) step();
        end
        DL_launch = 1'b0;
        step();
        n_cmp += 1;
        if (launch_next !== 1'b0) begin n_err++; $display("FAIL rmid_re_next_fall got %b want 0", launch_next); end
        step();
        $display("test_reset_mid reset in PULSE then relaunch done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_unit100();
        test_zero_delay();
        test_abort();
        test_input_change();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
